// File: rtl/wrf_dst_filter.sv
// Destination-MAC filter for the 16-bit WR fabric: buffers the frame header, decides pass/drop, forwards or discards.
// Define WRF_FILTER_BCAST_EN to also pass broadcast destinations while filtering is enabled.
module wrf_dst_filter #(
  parameter int g_hdr_depth = 4
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic        snk_we_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [1:0]  snk_sel_i,
  input  logic [15:0] snk_dat_i,
  output logic        snk_ack_o,
  output logic        snk_stall_o,
  output logic        snk_err_o,
  output logic        src_cyc_o,
  output logic        src_stb_o,
  output logic        src_we_o,
  output logic [1:0]  src_adr_o,
  output logic [1:0]  src_sel_o,
  output logic [15:0] src_dat_o,
  input  logic        src_ack_i,
  input  logic        src_stall_i,
  input  logic        src_err_i,
  input  logic        ena_i,
  input  logic [47:0] mac_i,
  output logic [31:0] pass_cnt_o,
  output logic [31:0] drop_cnt_o
);

  localparam int CW = $clog2(g_hdr_depth + 1);
  localparam int IW = (g_hdr_depth > 1) ? $clog2(g_hdr_depth) : 1;
  localparam logic [CW-1:0] DEPTH = CW'(g_hdr_depth);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FLUSH, S_PASS, S_DROP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] rd_reg, rd_next;
  logic [CW-1:0] base_cnt;
  logic [1:0]    dcnt_reg, dcnt_next, base_dcnt;
  logic [15:0]   dw0_reg, dw0_next, dw1_reg, dw1_next;
  logic          ended_reg, ended_next;
  logic          armed_reg, armed_next;
  logic          ack_reg;
  logic [31:0]   pass_cnt_reg, drop_cnt_reg;
  logic          pass_inc, drop_inc, buf_we;
  logic [19:0]   hdr_mem [g_hdr_depth];
  logic [19:0]   rd_word;
  logic          accept, start, hdr_take, is_data, dst_match, bcast_hit;
  logic [47:0]   dest;
  logic          unused_ok;

  assign unused_ok = &{1'b0, snk_we_i, src_ack_i, src_err_i};

  assign accept   = snk_cyc_i & snk_stb_i & ~snk_stall_o;
  // armed_reg ensures only a genuine rising cyc starts a frame (e.g. not the tail after a reset)
  assign start    = (state_reg == S_IDLE) & snk_cyc_i & armed_reg;
  assign hdr_take = accept & (start | (state_reg == S_HDR));
  assign is_data  = (snk_adr_i == 2'b00);
  assign base_cnt  = (state_reg == S_HDR) ? cnt_reg  : '0;
  assign base_dcnt = (state_reg == S_HDR) ? dcnt_reg : 2'd0;
  assign dest     = {dw0_reg, dw1_reg, snk_dat_i};

`ifdef WRF_FILTER_BCAST_EN
  assign bcast_hit = (dest == 48'hFFFF_FFFF_FFFF);
`else
  assign bcast_hit = 1'b0;
`endif

  assign dst_match = ~ena_i | (dest == mac_i) | bcast_hit;
  assign rd_word   = hdr_mem[rd_reg[IW-1:0]];

  assign snk_ack_o  = ack_reg;
  assign snk_err_o  = 1'b0;
  assign src_we_o   = src_cyc_o;
  assign pass_cnt_o = pass_cnt_reg;
  assign drop_cnt_o = drop_cnt_reg;

  always_comb begin
    snk_stall_o = 1'b0;
    src_cyc_o   = 1'b0;
    src_stb_o   = 1'b0;
    src_adr_o   = 2'b00;
    src_sel_o   = 2'b00;
    src_dat_o   = 16'h0000;
    case (state_reg)
      S_FLUSH: begin
        snk_stall_o = 1'b1;
        src_cyc_o   = 1'b1;
        src_stb_o   = 1'b1;
        {src_adr_o, src_sel_o, src_dat_o} = rd_word;
      end
      S_PASS: begin
        snk_stall_o = src_stall_i;
        src_cyc_o   = snk_cyc_i;
        src_stb_o   = snk_stb_i;
        src_adr_o   = snk_adr_i;
        src_sel_o   = snk_sel_i;
        src_dat_o   = snk_dat_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_next    = rd_reg;
    dcnt_next  = dcnt_reg;
    dw0_next   = dw0_reg;
    dw1_next   = dw1_reg;
    ended_next = ended_reg;
    pass_inc   = 1'b0;
    drop_inc   = 1'b0;
    buf_we     = 1'b0;
    if (!snk_cyc_i)
      armed_next = 1'b1;
    else if (start)
      armed_next = 1'b0;
    else
      armed_next = armed_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_HDR;
          cnt_next   = '0;
          dcnt_next  = 2'd0;
          rd_next    = '0;
          ended_next = 1'b0;
        end
      end
      S_HDR: begin
        if (!snk_cyc_i) begin
          drop_inc   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (!snk_cyc_i)
          ended_next = 1'b1;
        if (!src_stall_i) begin
          if (rd_reg == cnt_reg - CW'(1)) begin
            state_next = (ended_reg | ~snk_cyc_i) ? S_IDLE : S_PASS;
            ended_next = 1'b0;
          end else begin
            rd_next = rd_reg + CW'(1);
          end
        end
      end
      S_PASS, S_DROP: begin
        if (!snk_cyc_i)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Header word capture; the third data word carries the last destination chunk
    if (hdr_take) begin
      buf_we   = 1'b1;
      cnt_next = base_cnt + CW'(1);
      if (is_data) begin
        dcnt_next = base_dcnt + 2'd1;
        if (base_dcnt == 2'd0) dw0_next = snk_dat_i;
        if (base_dcnt == 2'd1) dw1_next = snk_dat_i;
      end
      if (is_data && base_dcnt == 2'd2) begin
        rd_next = '0;
        if (dst_match) begin
          pass_inc   = 1'b1;
          state_next = S_FLUSH;
        end else begin
          drop_inc   = 1'b1;
          state_next = S_DROP;
        end
      end else if (base_cnt + CW'(1) == DEPTH) begin
        drop_inc   = 1'b1;
        state_next = S_DROP;
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (buf_we)
      hdr_mem[base_cnt[IW-1:0]] <= {snk_adr_i, snk_sel_i, snk_dat_i};
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      rd_reg       <= '0;
      dcnt_reg     <= 2'd0;
      dw0_reg      <= 16'h0000;
      dw1_reg      <= 16'h0000;
      ended_reg    <= 1'b0;
      armed_reg    <= 1'b0;
      ack_reg      <= 1'b0;
      pass_cnt_reg <= 32'd0;
      drop_cnt_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rd_reg       <= rd_next;
      dcnt_reg     <= dcnt_next;
      dw0_reg      <= dw0_next;
      dw1_reg      <= dw1_next;
      ended_reg    <= ended_next;
      armed_reg    <= armed_next;
      ack_reg      <= accept;
      pass_cnt_reg <= pass_cnt_reg + {31'd0, pass_inc};
      drop_cnt_reg <= drop_cnt_reg + {31'd0, drop_inc};
    end
  end

endmodule

// File: tb/tb_wrf_dst_filter.sv
// Bench for wrf_dst_filter: directed frame table, reset-in-PASS sequence, then random frames vs a frame-level model.
module tb_wrf_dst_filter;
  localparam int DEPTH = 4;
  localparam logic [47:0] MY_MAC = 48'h0050_C200_0001;
`ifdef WRF_FILTER_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic snk_cyc, snk_stb, snk_we;
  logic [1:0] snk_adr, snk_sel;
  logic [15:0] snk_dat;
  logic snk_ack_o, snk_stall_o, snk_err_o;
  logic src_cyc_o, src_stb_o, src_we_o;
  logic [1:0] src_adr_o, src_sel_o;
  logic [15:0] src_dat_o;
  logic src_ack, src_stall, src_err;
  logic ena;
  logic [47:0] mac;
  logic [31:0] pass_cnt_o, drop_cnt_o;

  wrf_dst_filter #(.g_hdr_depth(DEPTH)) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n),
    .snk_cyc_i(snk_cyc), .snk_stb_i(snk_stb), .snk_we_i(snk_we),
    .snk_adr_i(snk_adr), .snk_sel_i(snk_sel), .snk_dat_i(snk_dat),
    .snk_ack_o(snk_ack_o), .snk_stall_o(snk_stall_o), .snk_err_o(snk_err_o),
    .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
    .src_adr_o(src_adr_o), .src_sel_o(src_sel_o), .src_dat_o(src_dat_o),
    .src_ack_i(src_ack), .src_stall_i(src_stall), .src_err_i(src_err),
    .ena_i(ena), .mac_i(mac),
    .pass_cnt_o(pass_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n_extra;
    int          n_data;
    logic [47:0] dst;
    logic        ena;
    int          stall_pct;
    int          cut;
    bit          exp_pass;
    int          exp_len;
  } vec_t;

  int vec_cnt = 0;
  int miss_cnt = 0;
  logic [19:0] tx_q[$];
  logic [19:0] rx_q[$];
  int ack_cnt;
  int hdr_len;
  bit chk_mirror;
  bit proto_bad;
  int exp_pass_total = 0;
  int exp_drop_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, observe after settling.
  task automatic step(input logic cyc, input logic stb, input logic [19:0] w,
                      input int stall_pct, output logic acc);
    @(negedge clk);
    snk_cyc = cyc;
    snk_stb = stb;
    {snk_adr, snk_sel, snk_dat} = w;
    src_stall = (int'($urandom_range(99)) < stall_pct);
    #1;
    acc = cyc & stb & ~snk_stall_o;
    if (src_we_o !== src_cyc_o || snk_err_o !== 1'b0) proto_bad = 1'b1;
    if (chk_mirror && src_cyc_o && rx_q.size() >= hdr_len && snk_stall_o !== src_stall)
      proto_bad = 1'b1;
    if (src_cyc_o && src_stb_o && !src_stall)
      rx_q.push_back({src_adr_o, src_sel_o, src_dat_o});
    if (snk_ack_o) ack_cnt++;
  endtask

  task automatic build(input int n_extra, input int n_data, input logic [47:0] dst);
    logic [15:0] d;
    tx_q.delete();
    tx_q.push_back({2'b10, 2'b11, 16'($urandom)});
    for (int i = 0; i < n_extra; i++)
      tx_q.push_back({($urandom_range(1) != 0) ? 2'b01 : 2'b11, 2'b11, 16'($urandom)});
    for (int i = 0; i < n_data; i++) begin
      d = (i < 3) ? dst[47 - 16*i -: 16] : 16'($urandom);
      tx_q.push_back({2'b00, 2'($urandom_range(3)), d});
    end
  endtask

  function automatic int third_data_pos();
    int seen = 0;
    for (int i = 0; i < tx_q.size(); i++)
      if (tx_q[i][19:18] == 2'b00) begin
        seen++;
        if (seen == 3) return i;
      end
    return -1;
  endfunction

  // Frame-level reference: the header must fit and arrive before cyc falls.
  function automatic bit model_pass(input int n, input logic en, input logic [47:0] m);
    logic [15:0] d[$];
    logic [47:0] dst;
    int p = third_data_pos();
    if (p < 0 || p >= DEPTH || p >= n) return 1'b0;
    foreach (tx_q[i]) if (tx_q[i][19:18] == 2'b00) d.push_back(tx_q[i][15:0]);
    dst = {d[0], d[1], d[2]};
    return !en || dst == m || (BCAST && dst == 48'hFFFF_FFFF_FFFF);
  endfunction

  task automatic run_frame(input string name, input int n, input int stall_pct,
                           input int gap_pct, input bit exp_pass, input int exp_len);
    logic acc;
    int idx, guard, low, bad, p;
    rx_q.delete();
    ack_cnt = 0;
    proto_bad = 1'b0;
    p = third_data_pos();
    hdr_len = (p < 0) ? 1000 : p + 1;
    chk_mirror = exp_pass;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 3000) begin
      step(1'b1, int'($urandom_range(99)) >= gap_pct, tx_q[idx], stall_pct, acc);
      if (acc) idx++;
      guard++;
    end
    check({name, "_accepted"}, idx, n);
    low = 0;
    guard = 0;
    while (low < 3 && guard < 300) begin
      step(1'b0, 1'b0, 20'h0, stall_pct, acc);
      low = src_cyc_o ? 0 : low + 1;
      guard++;
    end
    check({name, "_src_idle"}, low, 3);
    if (exp_pass) exp_pass_total++; else exp_drop_total++;
    check({name, "_rx_len"}, rx_q.size(), exp_len);
    bad = 0;
    for (int i = 0; i < exp_len; i++)
      if (i >= rx_q.size() || rx_q[i] !== tx_q[i]) bad++;
    check({name, "_rx_words_bad"}, bad, 0);
    check({name, "_acks"}, ack_cnt, n);
    check({name, "_pass_cnt"}, pass_cnt_o, exp_pass_total);
    check({name, "_drop_cnt"}, drop_cnt_o, exp_drop_total);
    check({name, "_proto"}, proto_bad, 0);
    $display("frame %s: %0d words in, %0d out, pass=%0d drop=%0d", name, n, rx_q.size(),
             pass_cnt_o, drop_cnt_o);
  endtask

  initial begin
    vec_t vecs[9];
    logic acc, pre_cyc;
    int idx, guard, rx_before, n, len, sel, stall, gap;
    logic [47:0] dst;
    bit pass;

    vecs[0] = '{"match",    0, 32, MY_MAC,                1'b1, 0,  0, 1'b1, 33};
    vecs[1] = '{"nomatch",  0, 32, 48'h0050_C200_0002,    1'b1, 0,  0, 1'b0, 0};
    vecs[2] = '{"bcast",    0, 32, 48'hFFFF_FFFF_FFFF,    1'b1, 0,  0, BCAST, BCAST ? 33 : 0};
    vecs[3] = '{"promisc",  0, 32, 48'h0050_C200_0002,    1'b0, 50, 0, 1'b1, 33};
    vecs[4] = '{"runt",     0, 2,  MY_MAC,                1'b1, 0,  0, 1'b0, 0};
    vecs[5] = '{"ended",    0, 3,  MY_MAC,                1'b1, 30, 0, 1'b1, 4};
    vecs[6] = '{"full",     3, 6,  MY_MAC,                1'b0, 0,  0, 1'b0, 0};
    vecs[7] = '{"oob_full", 1, 8,  MY_MAC,                1'b1, 0,  0, 1'b0, 0};
    vecs[8] = '{"cut_pass", 0, 10, MY_MAC,                1'b1, 40, 6, 1'b1, 6};

    rst_n = 1'b0;
    snk_cyc = 1'b0; snk_stb = 1'b0; snk_we = 1'b1;
    snk_adr = 2'b00; snk_sel = 2'b00; snk_dat = 16'h0;
    src_ack = 1'b0; src_stall = 1'b0; src_err = 1'b0;
    ena = 1'b1; mac = MY_MAC;
    chk_mirror = 1'b0; hdr_len = 1000; ack_cnt = 0; proto_bad = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {snk_ack_o, snk_stall_o, snk_err_o, src_cyc_o, src_stb_o, src_we_o,
                          src_adr_o, src_sel_o, src_dat_o}, 0);
    check("rst_pass_cnt", pass_cnt_o, 0);
    check("rst_drop_cnt", drop_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 20'h0, 0, acc);

    foreach (vecs[i]) begin
      ena = vecs[i].ena;
      mac = MY_MAC;
      build(vecs[i].n_extra, vecs[i].n_data, vecs[i].dst);
      n = (vecs[i].cut > 0) ? vecs[i].cut : tx_q.size();
      run_frame(vecs[i].name, n, vecs[i].stall_pct, 0, vecs[i].exp_pass, vecs[i].exp_len);
    end

    // Reset asserted while a frame is streaming through PASS.
    ena = 1'b1;
    mac = MY_MAC;
    build(0, 20, MY_MAC);
    rx_q.delete();
    chk_mirror = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 12 && guard < 200) begin
      step(1'b1, 1'b1, tx_q[idx], 0, acc);
      if (acc) idx++;
      guard++;
    end
    pre_cyc = src_cyc_o;
    check("pre_rst_in_pass", pre_cyc, 1);
    rst_n = 1'b0;
    #1;
    check("rst_src_cyc_async", src_cyc_o, 0);
    check("rst_mid_pass_cnt", pass_cnt_o, 0);
    check("rst_mid_drop_cnt", drop_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pass_total = 0;
    exp_drop_total = 0;
    rx_before = rx_q.size();
    guard = 0;
    while (idx < tx_q.size() && guard < 200) begin
      step(1'b1, 1'b1, tx_q[idx], 0, acc);
      if (acc) idx++;
      guard++;
    end
    repeat (4) step(1'b0, 1'b0, 20'h0, 0, acc);
    check("rst_tail_discarded", rx_q.size(), rx_before);
    check("rst_tail_pass_cnt", pass_cnt_o, 0);
    check("rst_tail_drop_cnt", drop_cnt_o, 0);
    build(0, 12, MY_MAC);
    run_frame("post_rst", tx_q.size(), 20, 0, 1'b1, tx_q.size());

    // Random frames against the frame-level model.
    for (int f = 0; f < 30; f++) begin
      mac = ($urandom_range(1) != 0) ? MY_MAC : {16'($urandom), $urandom};
      ena = ($urandom_range(4) != 0);
      sel = int'($urandom_range(3));
      case (sel)
        0: dst = mac;
        1: dst = mac ^ (48'h1 << $urandom_range(47));
        2: dst = 48'hFFFF_FFFF_FFFF;
        default: dst = {16'($urandom), $urandom};
      endcase
      build(($urandom_range(9) < 7) ? 0 : int'($urandom_range(3, 1)), int'($urandom_range(24)), dst);
      n = ($urandom_range(3) != 0) ? tx_q.size() : int'($urandom_range(tx_q.size(), 1));
      pass = model_pass(n, ena, mac);
      len = pass ? n : 0;
      stall = 25 * int'($urandom_range(2));
      gap = ($urandom_range(1) != 0) ? 20 : 0;
      run_frame($sformatf("rnd%0d", f), n, stall, gap, pass, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/wrf_dst_filter.md
# wrf_dst_filter

Destination-MAC filter on the 16-bit WR fabric (pipelined Wishbone, `adr`/`sel`/`dat`), placed between the core's external fabric source and the fabric loopback/consumer. Buffers each frame's status word and destination MAC, decides pass or drop, then forwards or silently discards the whole frame. Pass and drop decisions are counted for register readout by the parent.

## Interface
- `g_hdr_depth`, 4: header buffer entries, holding status/OOB/user words plus 3 data words.
- `clk_sys_i` in 1: system clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `snk_cyc_i`, `snk_stb_i`, `snk_we_i` in 1: fabric sink cycle, strobe and write enable. `we` is ignored.
- `snk_adr_i` in 2: word type. 00 data, 01 OOB, 10 status, 11 user.
- `snk_sel_i` in 2, `snk_dat_i` in 16: byte select and data.
- `snk_ack_o`, `snk_stall_o`, `snk_err_o` out 1: sink handshake. `err` is tied 0.
- `src_cyc_o`, `src_stb_o`, `src_we_o` out 1: fabric source. `we` equals `src_cyc_o`.
- `src_adr_o` out 2, `src_sel_o` out 2, `src_dat_o` out 16: forwarded word.
- `src_ack_i`, `src_stall_i`, `src_err_i` in 1: downstream handshake. `ack`/`err` are ignored.
- `ena_i` in 1: 0 selects promiscuous mode (every frame with a complete header passes).
- `mac_i` in 48: local MAC address; `mac_i[47:32]` is compared with the first data word.
- `pass_cnt_o`, `drop_cnt_o` out 32: frame counters, wrapping.

## Operation
- A word is accepted when `snk_cyc_i & snk_stb_i & ~snk_stall_o`.
- `snk_ack_o` is registered: it pulses exactly one cycle after each accepted word, in every state.
- FSM states: IDLE, HDR, FLUSH, PASS, DROP.
- IDLE: `snk_stall_o`=0. Rising `snk_cyc_i` clears the buffer and goes to HDR. A word accepted in that same cycle is buffered.
- HDR:
  - Every accepted word is buffered.
  - On the 3rd data word: decide PASS if `~ena_i`, or dest=`mac_i`, or (broadcast match, see Configuration); otherwise DROP. The decision increments the matching counter and moves to FLUSH or DROP.
  - Buffer full before the 3rd data word: drop.
  - `snk_cyc_i` falls before the decision: runt. Increment `drop_cnt_o` and return to IDLE without asserting `src_cyc_o`.
- FLUSH:
  - `snk_stall_o`=1 and `src_cyc_o`=1.
  - Emit buffered words in order, one per cycle while `~src_stall_i`; hold the word while stalled.
  - If `snk_cyc_i` fell during HDR/FLUSH after the decision, latch an "ended" flag. With the flag set, after the last buffered word drop `src_cyc_o` and go to IDLE. Otherwise go to PASS.
- PASS:
  - Combinational feed-through: `src_cyc/stb/adr/sel/dat_o` = sink inputs, `snk_stall_o` = `src_stall_i`.
  - Falling `snk_cyc_i` returns the block to IDLE.
- DROP: `snk_stall_o`=0, every word is acked and discarded, `src_cyc_o`=0. Falling `snk_cyc_i` returns to IDLE.
- No frame is ever truncated or reordered. Passed frames appear downstream byte-identical, including the status word.
- `mac_i` and `ena_i` are sampled only at the decision cycle.

## Timing
- Reset values: all outputs 0, counters 0, FSM IDLE, "ended" flag clear.
- Asserting `rst_n_i` mid-frame drops `src_cyc_o` immediately (async). The remainder of that sink frame is treated as a new frame only after `snk_cyc_i` next rises.
- Decision latency: FSM is in FLUSH/DROP the cycle after the 3rd data word is accepted.
  - FLUSH emits entry 0 in that cycle.
  - N buffered words take N cycles with no stall, then PASS (or IDLE when "ended" is set).
- Counters increment in the decision cycle (runt: the cycle `snk_cyc_i` is seen low). They wrap 0xFFFFFFFF→0.
- `snk_cyc_i` rising in the same cycle the FSM returns to IDLE is honoured: no frame is lost.
- No idle cycle is required between frames in DROP/runt. One idle `src_cyc_o` cycle follows every FLUSH-terminated frame.

## Configuration
- `WRF_FILTER_BCAST_EN` defined: dest=48'hFFFF_FFFF_FFFF also passes when `ena_i`=1.
- `WRF_FILTER_BCAST_EN` undefined: broadcast frames are dropped unless dest equals `mac_i`, or `ena_i`=0.

## Test plan
- `mac_i`=00:50:C2:00:00:01, `ena_i`=1, 64-byte frame (status + 32 data words) to that MAC, no stalls:
  - downstream receives 33 identical words;
  - `pass_cnt_o`=1;
  - 33 `snk_ack_o` pulses.
- Same setup, frame to 00:50:C2:00:00:02:
  - `src_cyc_o` stays 0;
  - all 33 words are acked;
  - `drop_cnt_o`=1.
- Broadcast frame with `ena_i`=1: passes with the macro defined, is dropped without it.
- `ena_i`=0, unmatched MAC, random `src_stall_i` at 50%:
  - frame passes intact and in order;
  - `snk_stall_o` mirrors `src_stall_i` in PASS.
- Runt frame (status + 2 data words, then `cyc` falls): no source cycle, `drop_cnt_o`+1. A 3-data-word frame ending during FLUSH is emitted completely, then `src_cyc_o` falls.
- `rst_n_i` pulsed during PASS:
  - `src_cyc_o`=0 immediately;
  - counters are 0;
  - the next full frame is filtered normally.
